// File: rtl/sop_lut_eval.sv
// sop_lut_eval: run-time loadable per-channel truth-table evaluator; SOP_LUT_HIT_COUNT_EN adds saturating per-channel hit counters
module sop_lut_eval #(
  parameter int N_IN     = 5,
  parameter int CHANNELS = 2,
  parameter int CFG_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [CFG_W-1:0]        cfg_data_i,
  output logic                    cfg_done_o,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [N_IN-1:0]         in_vec_i,
  output logic                    out_valid_o,
  output logic [CHANNELS-1:0]     out_bits_o,
  output logic [16*CHANNELS-1:0]  hit_count_o
);
  localparam int T     = 1 << N_IN;
  localparam int TW    = CHANNELS * T;
  localparam int WORDS = TW / CFG_W;
  localparam int CW    = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;
  state_t              state_q, state_d;
  logic [TW-1:0]       table_q, table_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d, ov_q, ov_d;
  logic [CHANNELS-1:0] ob_q, ob_d, lut;
  logic                cfg_acc, in_acc, last;
  assign cfg_ready_o = state_q == LOAD;
  assign in_ready_o  = state_q == READY;
  assign cfg_acc     = cfg_valid_i & cfg_ready_o & ~cfg_start_i;
  assign in_acc      = in_valid_i & in_ready_o;
  assign last        = cnt_q == CW'(WORDS - 1);
  assign cfg_done_o  = done_q;
  assign out_valid_o = ov_q;
  assign out_bits_o  = ob_q;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lut
    logic [T-1:0] sl;
    assign sl     = table_q[c*T +: T];
    assign lut[c] = sl[in_vec_i];
  end
  // next state: restart beats a same-cycle word; evaluation uses the table as it stands this cycle
  always_comb begin
    state_d = cfg_start_i ? LOAD : (cfg_acc && last) ? READY : state_q;
    cnt_d   = cfg_start_i ? '0 : cfg_acc ? cnt_q + 1'b1 : cnt_q;
    table_d = table_q;
    if (cfg_acc) table_d[int'(cnt_q)*CFG_W +: CFG_W] = cfg_data_i;
    done_d  = cfg_acc & last;
    ov_d    = in_acc;
    ob_d    = in_acc ? lut : ob_q;
  end
  // state, table and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      table_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      ob_q    <= '0;
    end else begin
      state_q <= state_d;
      table_q <= table_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
      ob_q    <= ob_d;
    end
  end
`ifdef SOP_LUT_HIT_COUNT_EN
  logic [16*CHANNELS-1:0] hit_q, hit_d;
  // count presented 1-results per channel, saturating; a new load clears them
  always_comb begin
    hit_d = hit_q;
    for (int c = 0; c < CHANNELS; c++)
      hit_d[16*c +: 16] = cfg_start_i ? 16'd0 :
        (ov_q && ob_q[c] && hit_q[16*c +: 16] != 16'hFFFF) ? hit_q[16*c +: 16] + 16'd1 : hit_q[16*c +: 16];
  end
  // hit counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_q <= '0;
    else hit_q <= hit_d;
  end
  assign hit_count_o = hit_q;
`else
  assign hit_count_o = '0;
`endif
endmodule

// File: tb/tb_sop_lut_eval.sv
// tb_sop_lut_eval: directed stimulus with a queue scoreboard checked by an output monitor
module tb_sop_lut_eval;
  logic        clk, rst;
  logic        cfg_start, cfg_valid, cfg_ready, cfg_done;
  logic [7:0]  cfg_data;
  logic        in_valid, in_ready, out_valid;
  logic [4:0]  in_vec;
  logic [1:0]  out_bits;
  logic [31:0] hit_count;
  logic [1:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  vv[8] = '{5'd0, 5'd1, 5'd4, 5'd30, 5'd15, 5'd13, 5'd17, 5'd26};
  logic [1:0]  ee[8] = '{2'b11, 2'b00, 2'b11, 2'b01, 2'b00, 2'b11, 2'b11, 2'b01};

  sop_lut_eval dut (
    .clk(clk), .rst(rst),
    .cfg_start_i(cfg_start), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_data_i(cfg_data), .cfg_done_o(cfg_done),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_vec_i(in_vec),
    .out_valid_o(out_valid), .out_bits_o(out_bits), .hit_count_o(hit_count)
  );

  initial begin
    clk = 0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  always @(negedge clk)
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %b expected no output", out_bits);
      end else chk("out_bits", out_bits, exp_q.pop_front());
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    cfg_start = 1;
    tick();
    cfg_start = 0;
  endtask

  task automatic word(input logic [7:0] d);
    cfg_valid = 1;
    cfg_data  = d;
    tick();
    cfg_valid = 0;
  endtask

  task automatic eval(input logic [4:0] v, input logic [1:0] e);
    in_valid = 1;
    in_vec   = v;
    exp_q.push_back(e);
    tick();
    in_valid = 0;
  endtask

  initial begin
    rst = 0; cfg_start = 0; cfg_valid = 0; cfg_data = 0; in_valid = 0; in_vec = 0;
    // 1: async reset with no clock running
    #3 rst = 1;
    #1;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_hit", hit_count, 0);
    @(negedge clk);
    rst = 0;
    tick();
    // 2: full load of 01..08
    start();
    chk("load_ready", cfg_ready, 1);
    for (int k = 0; k < 8; k++) begin
      word(8'(k + 1));
      if (k < 7) begin
        chk("load_ready_mid", cfg_ready, 1);
        chk("load_done_early", cfg_done, 0);
      end else begin
        chk("load_done", cfg_done, 1);
        chk("load_in_ready", in_ready, 1);
        chk("load_ready_end", cfg_ready, 0);
      end
    end
    tick();
    chk("done_pulse", cfg_done, 0);
    eval(5'd0, 2'b11);
    eval(5'd1, 2'b00);
    eval(5'd2, 2'b10);
    eval(5'd8, 2'b00);
    eval(5'd9, 2'b11);
    // 3: ch0=0000_0002, ch1=8000_0000
    start();
    word(8'h02); word(8'h00); word(8'h00); word(8'h00);
    word(8'h00); word(8'h00); word(8'h00); word(8'h80);
    eval(5'd1, 2'b01);
    eval(5'd31, 2'b10);
    tick();
    chk("idle_valid", out_valid, 0);
    chk("idle_hold", out_bits, 2'b10);
    eval(5'd1, 2'b01);
    in_valid = 1; in_vec = 5'd31; cfg_start = 1;
    exp_q.push_back(2'b10);
    tick();
    in_valid = 0; cfg_start = 0;
    chk("restart_cfg_ready", cfg_ready, 1);
    chk("restart_in_ready", in_ready, 0);
    in_valid = 1; in_vec = 5'd0;
    tick();
    in_valid = 0;
    // 4: restart mid-load drops the coincident word
    word(8'hAA); word(8'hBB); word(8'hCC);
    cfg_start = 1; cfg_valid = 1; cfg_data = 8'hEE;
    tick();
    cfg_start = 0; cfg_valid = 0;
    chk("restart_ready", cfg_ready, 1);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) begin
        tick();
        chk("gap_done", cfg_done, 0);
      end
      word(8'(8'h11 * (k + 1)));
      chk("restart_done", cfg_done, k == 7);
    end
    for (int i = 0; i < 8; i++) eval(vv[i], ee[i]);
    cfg_valid = 1; cfg_data = 8'hFF;
    tick();
    cfg_valid = 0;
    chk("ignored_word_ready", in_ready, 1);
    eval(5'd1, 2'b00);
    eval(5'd0, 2'b11);
    // 5: async reset mid-load, then all-ones load
    start();
    repeat (5) word(8'hFF);
    #2 rst = 1;
    #1;
    chk("rst2_cfg_ready", cfg_ready, 0);
    chk("rst2_in_ready", in_ready, 0);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_bits", out_bits, 0);
    @(negedge clk);
    rst = 0;
    tick();
    in_valid = 1;
    tick();
    in_valid = 0;
    chk("empty_in_ready", in_ready, 0);
    start();
    repeat (8) word(8'hFF);
    for (int v = 0; v < 32; v++) eval(5'(v), 2'b11);
    tick();
    tick();
`ifdef SOP_LUT_HIT_COUNT_EN
    chk("hit_32", hit_count, {16'd32, 16'd32});
    // 6: saturation on ch0 only
    start();
    chk("hit_clear", hit_count, 0);
    repeat (4) word(8'hFF);
    repeat (4) word(8'h00);
    for (int i = 0; i < 70000; i++) eval(5'(i), 2'b01);
    tick();
    tick();
    chk("hit_sat", hit_count, {16'h0000, 16'hFFFF});
    start();
    chk("hit_clear2", hit_count, 0);
`else
    chk("hit_off", hit_count, 0);
`endif
    tick();
    chk("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
